// File: rtl/addr_pkg.sv
// Shared types and widths for the SRAM address loader.
package addr_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      COMMIT
   } state_t;

   localparam int DEF_ADDR_WIDTH = 21;
   localparam int DEF_TIMEOUT    = 255;
   localparam int BIT_CNT_W      = $clog2(DEF_ADDR_WIDTH + 1);
   localparam int IDLE_CNT_W     = $clog2(DEF_TIMEOUT + 1);

endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchronizer for an asynchronous level, with single-cycle
// rise/fall pulses derived from the synchronized value.
module sync_edge #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic rise,
   output logic fall
);

   logic [SYNC_STAGES-1:0] sync_p0;
   logic                   prev_p1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_p0 <= '0;
         prev_p1 <= 1'b0;
      end else begin
         sync_p0 <= {sync_p0[SYNC_STAGES-2:0], din};
         prev_p1 <= sync_p0[SYNC_STAGES-1];
      end
   end

   assign rise = sync_p0[SYNC_STAGES-1] & ~prev_p1;
   assign fall = ~sync_p0[SYNC_STAGES-1] & prev_p1;

endmodule

// File: rtl/addr_loader.sv
// Serial SRAM address loader with counter increments.
// Define ADDR_AUTOINC_EN to also increment on each access_done pulse.
module addr_loader
   import addr_pkg::*;
#(
   parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
   parameter int SYNC_STAGES = 2,
   parameter int TIMEOUT     = DEF_TIMEOUT
) (
   input  logic                  avr_clk,
   input  logic                  avr_reset_n,
   input  logic                  avr_si,
   input  logic                  avr_sreg_en,
   input  logic                  avr_counter,
   input  logic                  access_done,
   output logic [ADDR_WIDTH-1:0] sram_addr,
   output logic                  addr_valid,
   output logic                  busy
);

   state_t                  state, state_nxt;
   logic [SYNC_STAGES-1:0]  si_sync_p0;
   logic                    si_sync;
   logic                    strobe_rise, strobe_fall;
   logic                    cnt_rise, cnt_fall;
   logic                    inc_p1;
   logic                    inc_req;
   logic [ADDR_WIDTH-1:0]   shreg;
   logic [BIT_CNT_W-1:0]    bit_cnt;
   logic [IDLE_CNT_W-1:0]   idle_cnt;
   logic                    shift_en, commit, abort, idle_tick;

   sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_strobe_sync (
      .clk   (avr_clk),
      .rst_n (avr_reset_n),
      .din   (avr_sreg_en),
      .rise  (strobe_rise),
      .fall  (strobe_fall)
   );

   sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_counter_sync (
      .clk   (avr_clk),
      .rst_n (avr_reset_n),
      .din   (avr_counter),
      .rise  (cnt_rise),
      .fall  (cnt_fall)
   );

   assign si_sync = si_sync_p0[SYNC_STAGES-1];

`ifdef ADDR_AUTOINC_EN
   assign inc_req = inc_p1 | access_done;
   logic unused_ok;
   assign unused_ok = &{1'b0, strobe_fall, cnt_rise};
`else
   assign inc_req = inc_p1;
   logic unused_ok;
   assign unused_ok = &{1'b0, strobe_fall, cnt_rise, access_done};
`endif

   always_ff @(posedge avr_clk or negedge avr_reset_n) begin
      if (!avr_reset_n) state <= IDLE;
      else              state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      shift_en  = 1'b0;
      commit    = 1'b0;
      abort     = 1'b0;
      idle_tick = 1'b0;
      case (state)
         IDLE: begin
            if (strobe_rise) begin
               shift_en  = 1'b1;
               state_nxt = SHIFT;
            end
         end
         SHIFT: begin
            if (strobe_rise) begin
               shift_en = 1'b1;
               if (bit_cnt == BIT_CNT_W'(ADDR_WIDTH - 1)) state_nxt = COMMIT;
            end else if (idle_cnt == IDLE_CNT_W'(TIMEOUT - 1)) begin
               abort     = 1'b1;
               state_nxt = IDLE;
            end else begin
               idle_tick = 1'b1;
            end
         end
         COMMIT: begin
            commit    = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Stage p0: si synchronizer; stage p1: increment request delayed to line up with commit.
   always_ff @(posedge avr_clk or negedge avr_reset_n) begin
      if (!avr_reset_n) begin
         si_sync_p0 <= '0;
         inc_p1     <= 1'b0;
         shreg      <= '0;
         bit_cnt    <= '0;
         idle_cnt   <= '0;
         sram_addr  <= '0;
         addr_valid <= 1'b0;
      end else begin
         si_sync_p0 <= {si_sync_p0[SYNC_STAGES-2:0], avr_si};
         inc_p1     <= cnt_fall;

         if (shift_en) begin
            shreg    <= {shreg[ADDR_WIDTH-2:0], si_sync};
            bit_cnt  <= bit_cnt + BIT_CNT_W'(1);
            idle_cnt <= '0;
         end else if (idle_tick) begin
            idle_cnt <= idle_cnt + IDLE_CNT_W'(1);
         end

         if (abort) begin
            shreg    <= '0;
            bit_cnt  <= '0;
            idle_cnt <= '0;
         end

         // A commit overrides any increment landing in the same cycle.
         if (commit) begin
            sram_addr  <= shreg;
            addr_valid <= 1'b1;
            bit_cnt    <= '0;
            idle_cnt   <= '0;
         end else if (inc_req) begin
            sram_addr  <= sram_addr + ADDR_WIDTH'(1);
         end
      end
   end

   assign busy = (state != IDLE);

endmodule

// File: tb/tb_addr_loader.sv
// Directed bench for addr_loader: frame load, wrap, timeout, collisions, reset.
module tb_addr_loader;

   logic        avr_clk = 1'b0;
   logic        avr_reset_n;
   logic        avr_si;
   logic        avr_sreg_en;
   logic        avr_counter;
   logic        access_done;
   logic [20:0] sram_addr;
   logic        addr_valid;
   logic        busy;

   int checks = 0;
   int errors = 0;

   addr_loader dut (
      .avr_clk     (avr_clk),
      .avr_reset_n (avr_reset_n),
      .avr_si      (avr_si),
      .avr_sreg_en (avr_sreg_en),
      .avr_counter (avr_counter),
      .access_done (access_done),
      .sram_addr   (sram_addr),
      .addr_valid  (addr_valid),
      .busy        (busy)
   );

   always #5 avr_clk = ~avr_clk;

   task automatic tick(input int n);
      repeat (n) @(posedge avr_clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic send_bit(input logic b);
      avr_si      = b;
      avr_sreg_en = 1'b0;
      tick(4);
      avr_sreg_en = 1'b1;
      tick(4);
   endtask

   task automatic send_frame(input logic [20:0] v);
      for (int i = 20; i >= 0; i--) send_bit(v[i]);
   endtask

   task automatic counter_pulse();
      avr_counter = 1'b0;
      tick(4);
      avr_counter = 1'b1;
      tick(4);
   endtask

   task automatic do_reset();
      avr_sreg_en = 1'b0;
      tick(4);
      avr_reset_n = 1'b0;
      tick(2);
      avr_reset_n = 1'b1;
      tick(2);
   endtask

   initial begin
      logic [20:0] v;
      avr_reset_n = 1'b0;
      avr_si      = 1'b0;
      avr_sreg_en = 1'b0;
      avr_counter = 1'b1;
      access_done = 1'b0;
      tick(2);
      check("rst_addr", 32'(sram_addr), 32'h0);
      check("rst_valid", 32'(addr_valid), 32'h0);
      check("rst_busy", 32'(busy), 32'h0);
      avr_reset_n = 1'b1;
      tick(2);

      // Full frame 0x0A5A5A with exact commit latency
      v = 21'h0A5A5A;
      send_bit(v[20]);
      check("busy_first_edge", 32'(busy), 32'h1);
      for (int i = 19; i >= 1; i--) send_bit(v[i]);
      avr_si      = v[0];
      avr_sreg_en = 1'b0;
      tick(4);
      avr_sreg_en = 1'b1;
      tick(3);
      check("pre_commit_addr", 32'(sram_addr), 32'h0);
      check("pre_commit_busy", 32'(busy), 32'h1);
      tick(1);
      check("commit_addr", 32'(sram_addr), 32'h0A5A5A);
      check("commit_valid", 32'(addr_valid), 32'h1);
      check("commit_busy", 32'(busy), 32'h0);

      // Wrap from all-ones
      send_frame(21'h1FFFFF);
      check("ones_addr", 32'(sram_addr), 32'h1FFFFF);
      counter_pulse();
      check("wrap_addr", 32'(sram_addr), 32'h000000);
      check("wrap_valid", 32'(addr_valid), 32'h1);

      // Partial frame aborted by timeout
      do_reset();
      for (int i = 0; i < 10; i++) send_bit(i[0]);
      check("partial_busy", 32'(busy), 32'h1);
      tick(200);
      check("timeout_pending_busy", 32'(busy), 32'h1);
      tick(100);
      check("timeout_busy", 32'(busy), 32'h0);
      check("timeout_addr", 32'(sram_addr), 32'h0);
      check("timeout_valid", 32'(addr_valid), 32'h0);

      // Counter increment colliding with commit of 0x000100
      v = 21'h000100;
      for (int i = 20; i >= 1; i--) send_bit(v[i]);
      avr_si      = v[0];
      avr_sreg_en = 1'b0;
      tick(4);
      avr_sreg_en = 1'b1;
      avr_counter = 1'b0;
      tick(4);
      check("collide_addr", 32'(sram_addr), 32'h000100);
      avr_counter = 1'b1;
      tick(4);
      check("collide_after_rise", 32'(sram_addr), 32'h000100);
      counter_pulse();
      check("inc_after_collide", 32'(sram_addr), 32'h000101);

      // Reset mid-frame, then a fresh frame
      for (int i = 0; i < 15; i++) send_bit(1'b1);
      avr_sreg_en = 1'b0;
      tick(4);
      check("midframe_busy", 32'(busy), 32'h1);
      avr_reset_n = 1'b0;
      #1;
      check("async_rst_addr", 32'(sram_addr), 32'h0);
      check("async_rst_valid", 32'(addr_valid), 32'h0);
      check("async_rst_busy", 32'(busy), 32'h0);
      tick(1);
      avr_reset_n = 1'b1;
      tick(2);
      send_frame(21'h000003);
      check("fresh_addr", 32'(sram_addr), 32'h000003);
      check("fresh_valid", 32'(addr_valid), 32'h1);

`ifdef ADDR_AUTOINC_EN
      send_frame(21'h000010);
      for (int i = 0; i < 3; i++) begin
         access_done = 1'b1;
         tick(1);
         access_done = 1'b0;
         tick(1);
      end
      check("autoinc_addr", 32'(sram_addr), 32'h000013);
      avr_counter = 1'b0;
      tick(3);
      access_done = 1'b1;
      tick(1);
      access_done = 1'b0;
      check("dual_inc_addr", 32'(sram_addr), 32'h000014);
      avr_counter = 1'b1;
      tick(4);
`else
      access_done = 1'b1;
      tick(1);
      access_done = 1'b0;
      tick(1);
      check("access_done_ignored", 32'(sram_addr), 32'h000003);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/addr_loader.md
# addr_loader

Address front end for the SRAM bus path. Receives the 21-bit SRAM address serially from the AVR over `avr_si`/`avr_sreg_en` and holds it as the committed `sram_addr`. Applies increments from `avr_counter` and, optionally, from completed bus accesses. Sits directly upstream of the bus FSM, which consumes `sram_addr` and returns `access_done`.

## Interface
Parameters:
- `ADDR_WIDTH`, 21, width of the SRAM address and of the serial frame.
- `SYNC_STAGES`, 2, flip-flop depth of each input synchronizer (≥2).
- `TIMEOUT`, 255, idle `avr_clk` cycles in SHIFT before a partial frame is aborted.

Ports:
- `avr_clk` in 1: the single clock.
- `avr_reset_n` in 1: asynchronous, active-low reset.
- `avr_si` in 1: serial address bit, MSB first. Sampled on the `avr_sreg_en` rising edge.
- `avr_sreg_en` in 1: shift strobe from the AVR, asynchronous to `avr_clk`. Each rising edge shifts in one bit.
- `avr_counter` in 1: active-low increment request, asynchronous. Each falling edge requests +1.
- `access_done` in 1: one-cycle pulse from the bus FSM marking a completed SRAM access.
- `sram_addr` out ADDR_WIDTH: committed address.
- `addr_valid` out 1: high once a full frame has been committed since reset.
- `busy` out 1: high while a frame is being shifted in.

## Operation
- `avr_si`, `avr_sreg_en` and `avr_counter` each pass through a SYNC_STAGES synchronizer. Edge detection runs on the synchronized value.
- FSM states:
  - IDLE: no frame in progress. The first strobe edge shifts in bit 0 and moves to SHIFT.
  - SHIFT: each strobe edge does `shreg <= {shreg[ADDR_WIDTH-2:0], si_sync}` and increments `bit_cnt`.
    - When the bit that makes `bit_cnt` reach ADDR_WIDTH is shifted in, go to COMMIT.
    - If `idle_cnt` reaches TIMEOUT with no strobe edge, go to IDLE. `shreg` is discarded and `sram_addr` is unchanged.
  - COMMIT: lasts one cycle. `sram_addr <= shreg`, `addr_valid <= 1`, `bit_cnt` and `idle_cnt` clear, then go to IDLE.
- `busy` = (state != IDLE).
- Increment:
  - A synchronized falling edge of `avr_counter` sets `sram_addr <= sram_addr + 1` (mod 2^ADDR_WIDTH). 0x1FFFFF wraps to 0x000000.
  - Increments are allowed in every state. They act on `sram_addr` only, never on `shreg`.
- Simultaneous events:
  - Commit and increment in the same cycle: the commit wins and the increment is dropped.
  - Two increment sources in the same cycle: a single +1 is applied.
- Reset, including mid-frame: `sram_addr`=0, `addr_valid`=0, `busy`=0, state IDLE, `shreg`/`bit_cnt`/`idle_cnt`=0.
- `addr_valid` never deasserts except on reset.

## Timing
- Input edge to internal edge pulse: SYNC_STAGES+1 cycles.
- Last strobe rising edge to `sram_addr` update: SYNC_STAGES+2 cycles. `busy` falls in the same cycle.
- `avr_counter` falling edge to `sram_addr` +1: SYNC_STAGES+2 cycles.
- `access_done` (when enabled) to `sram_addr` +1: 1 cycle.
- AVR requirements:
  - `avr_sreg_en` and `avr_counter` must hold each level for ≥ SYNC_STAGES+1 cycles. Shorter pulses may be lost.
  - `avr_si` must be stable for ≥ SYNC_STAGES+1 cycles before the strobe rising edge.
- Frame duration is unbounded as long as strobe gaps stay below TIMEOUT cycles.

## Configuration
- `ADDR_AUTOINC_EN` defined: each `access_done` pulse increments `sram_addr`. This enables streaming block transfers without AVR counter pulses. The same collision rules apply.
- Not defined: `access_done` is ignored and only `avr_counter` increments. The port remains present.

## Structure
- Package `addr_pkg`:
  - State enum {IDLE, SHIFT, COMMIT}.
  - Default ADDR_WIDTH.
  - Localparam for the `bit_cnt` width, $clog2(ADDR_WIDTH+1).
  - Localparam for the `idle_cnt` width.
- Sub-module `sync_edge`: synchronizer plus rise/fall pulse outputs, parameterized by SYNC_STAGES. Instantiated for `avr_sreg_en` and `avr_counter`. `avr_si` uses a plain synchronizer of the same depth.

## Test plan
- Shift 21 bits of 0x0A5A5A MSB first, 4 cycles per level. Expect:
  - `busy`=1 from the first edge.
  - `sram_addr`=0x0A5A5A and `addr_valid`=1 exactly SYNC_STAGES+2 cycles after the 21st edge.
  - `busy`=0 at that point.
- Commit 0x1FFFFF, then one `avr_counter` low pulse. Expect `sram_addr`=0x000000; `addr_valid` stays 1.
- Shift 10 bits, then hold the strobe for 300 cycles. Expect `busy`=0 after TIMEOUT, `sram_addr` unchanged (0x000000 after reset), `addr_valid`=0.
- Time an `avr_counter` falling edge so its increment lands on the COMMIT cycle of 0x000100. Expect `sram_addr`=0x000100, not 0x000101.
- Assert `avr_reset_n` low for 1 cycle after 15 shifted bits. Expect all outputs 0 immediately. A fresh 21-bit frame of 0x000003 then commits correctly.
- With `ADDR_AUTOINC_EN`, commit 0x000010 and send 3 `access_done` pulses. Expect 0x000013. Send `access_done` coincident with a counter increment. Expect 0x000014.
